sr_pulse_driver: RTL and testbench
==================================

# sr_pulse_driver

Synchronous write controller for the team's NAND-based SR latch cells (2-input, 3-input and mixed variants). It accepts a single-bit write request on a clock edge and converts it into one timed active-low set or reset pulse on the latch's `s`/`r` inputs. It then holds both inputs inactive for a settle window, so the pulse width and recovery time always exceed the latch's worst-case 12 ns NAND delay. Optionally it reads back `q`/`qbar` and flags a failed or illegal latch state.

## Interface
- `PULSE_CYC`, default 2: cycles the selected active-low input is held low; legal range ≥1.
- `SETTLE_CYC`, default 2: cycles both inputs are held high after the pulse, before completion; legal range ≥1.
- `clk`  input  1  single clock, rising-edge.
- `rst`  input  1  reset; asynchronous and active-high.
- `req`  input  1  write request; sampled only when `ready`=1.
- `din`  input  1  value to store (1 = set, 0 = reset); captured with `req`.
- `ready`  output  1  idle, able to accept `req`.
- `done`  output  1  one-cycle completion strobe.
- `err`  output  1  readback failure; held until the next accepted request.
- `s_n`  output  1  active-low set, wired to latch `s`.
- `r_n`  output  1  active-low reset, wired to latch `r`.
- `q_fb`  input  1  latch `q` feedback.
- `qbar_fb`  input  1  latch `qbar` feedback.

## Operation
- Registered outputs; reset values: `s_n`=1, `r_n`=1, `ready`=1, `done`=0, `err`=0, state IDLE, counter 0, captured bit 0.
- States:
  - IDLE: `ready`=1. If `req`=1 at an edge, capture `din`, clear `err`, go to PULSE.
  - PULSE: exactly one of `s_n`/`r_n` is low (`s_n` if the captured bit is 1, else `r_n`). Hold for PULSE_CYC cycles, then go to SETTLE.
  - SETTLE: both high for SETTLE_CYC cycles, then go to CHECK.
  - CHECK: `done`=1 for one cycle, `err` updated, then IDLE.
- `s_n` and `r_n` are never both low, in any state or during reset.
- `req` while `ready`=0 is ignored (not queued). `req` held high continuously starts back-to-back writes, each taking the full sequence.
- Counter is a down-counter of width `$clog2(max(PULSE_CYC,SETTLE_CYC)+1)`. It is loaded on entry to PULSE and SETTLE, and the state exits when it reaches 1. No wrap-around is possible.
- `q_fb`/`qbar_fb` are sampled only in CHECK. They are not synchronized, because the latch is driven only by this block and has settled by then.
- Reset asserted mid-operation: `s_n`/`r_n` return high immediately (asynchronously), with no partial completion and no `done`. The latch keeps whatever state it reached.

## Timing
- With edge 0 the accepting edge:
  - Pulse low during cycles 1..PULSE_CYC.
  - Both inputs high during cycles PULSE_CYC+1..PULSE_CYC+SETTLE_CYC.
  - `done` high in cycle PULSE_CYC+SETTLE_CYC+1.
  - `ready` high again in cycle PULSE_CYC+SETTLE_CYC+2.
- Total occupancy is PULSE_CYC+SETTLE_CYC+2 cycles per write. With defaults this is 6 cycles.
- `err` becomes valid in the same cycle as `done`.
- Clock period × PULSE_CYC and clock period × SETTLE_CYC must each be ≥ 24 ns (two 12 ns NAND stages). At a 10 ns clock, the defaults give 20 ns, so the bench uses PULSE_CYC=3, SETTLE_CYC=3 at 10 ns.

## Configuration
- `SR_READBACK_EN` defined:
  - In CHECK, `err`=1 if `q_fb`≠captured bit, or if `q_fb`==`qbar_fb` (both outputs 1 is the illegal/metastable state).
  - Otherwise `err`=0.
- `SR_READBACK_EN` undefined:
  - `q_fb`/`qbar_fb` are unused and `err` is constant 0.
  - The sequence and timing are otherwise identical.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, released → `s_n`=`r_n`=1, `ready`=1, `done`=`err`=0; no output change for 10 cycles with `req`=0.
- Set write: `req`=1, `din`=1 at edge 0, with PULSE_CYC=3, SETTLE_CYC=3 and a real `SR2input` cell attached → `s_n` low cycles 1–3 only, `r_n` always 1, `done` in cycle 7, `q_fb`=1, `err`=0, `ready` in cycle 8.
- Reset write after set: `din`=0 → `r_n` low cycles 1–3, `q_fb`=0, `qbar_fb`=1, `err`=0.
- Busy request: pulse `req` with `din`=0 during cycle 2 of a `din`=1 write → ignored; exactly one `done`; latch stays 1.
- Readback failure (`SR_READBACK_EN`): bench forces `q_fb`=0, `qbar_fb`=0 while writing `din`=1 → `err`=1 with `done`. The next accepted request clears `err`; forcing `q_fb`=`qbar_fb`=1 also gives `err`=1.
- Reset mid-pulse: assert `rst` at cycle 2 of a set pulse → `s_n` high within the same cycle (asynchronous), no `done`, `ready`=1 after release.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - timed active-low set/reset pulse driver for NAND SR latch cells
// Optional feature macro: SR_READBACK_EN (q/qbar readback and err flag)
module sr_pulse_driver #(
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic din,
    output logic ready,
    output logic done,
    output logic err,
    output logic s_n,
    output logic r_n,
    input  logic q_fb,
    input  logic qbar_fb
);

    localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_din;
    logic             w_din_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_err_chk;
    logic             w_accept;
    logic             r_ready;
    logic             r_done;
    logic             r_s_n;
    logic             r_r_n;
    logic             w_ready_nxt;
    logic             w_done_nxt;
    logic             w_s_n_nxt;
    logic             w_r_n_nxt;

    assign w_accept = (r_state == IDLE) && req;

`ifdef SR_READBACK_EN
    // Both latch outputs equal means the illegal or metastable state.
    assign w_err_chk = (q_fb != r_din) || (q_fb == qbar_fb);
`else
    logic w_unused_fb;
    assign w_unused_fb = q_fb ^ qbar_fb;
    assign w_err_chk   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_din   <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_s_n   <= 1'b1;
            r_r_n   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_din   <= w_din_nxt;
            r_err   <= w_err_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_s_n   <= w_s_n_nxt;
            r_r_n   <= w_r_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_din_nxt   = r_din;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = CNT_W'(PULSE_CYC);
                    w_din_nxt   = din;
                end
            end
            PULSE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYC);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_ready_nxt = (w_state_nxt == IDLE);
        w_done_nxt  = (w_state_nxt == CHECK);
        w_s_n_nxt   = !((w_state_nxt == PULSE) && w_din_nxt);
        w_r_n_nxt   = !((w_state_nxt == PULSE) && !w_din_nxt);
        w_err_nxt   = r_err;
        if (w_accept) begin
            w_err_nxt = 1'b0;
        end else if (r_state == CHECK) begin
            w_err_nxt = w_err_chk;
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign s_n   = r_s_n;
    assign r_n   = r_r_n;
    // Readback is evaluated during CHECK itself so err lines up with done, then held.
    assign err   = (r_state == CHECK) ? w_err_chk : r_err;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - self-checking bench for sr_pulse_driver with a NAND SR latch model
module tb_sr_pulse_driver;

    localparam int P = 3;
    localparam int S = 3;
`ifdef SR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic din = 1'b0;
    logic ready, done, err, s_n, r_n;
    logic q_fb, qbar_fb;
    logic lat_q = 1'b0;
    int   fmode = 0;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic din;
        int   fmode;
        logic exp_q;
        logic exp_err;
    } vec_t;

    typedef struct {
        logic err;
        logic q;
        bit   chk_q;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    sr_pulse_driver #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .din    (din),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .s_n    (s_n),
        .r_n    (r_n),
        .q_fb   (q_fb),
        .qbar_fb(qbar_fb)
    );

    always #5 clk = ~clk;

    always @(s_n or r_n) begin
        if (!s_n) lat_q = 1'b1;
        else if (!r_n) lat_q = 1'b0;
    end

    always_comb begin
        case (fmode)
            1:       {q_fb, qbar_fb} = 2'b00;
            2:       {q_fb, qbar_fb} = 2'b11;
            default: {q_fb, qbar_fb} = {lat_q, ~lat_q};
        endcase
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 30 && ready !== 1'b1; i++) @(negedge clk);
        chk("ready_timeout", ready, 1);
    endtask

    task automatic do_write(input vec_t v);
        exp_t e;
        wait_ready();
        fmode   = v.fmode;
        req     = 1'b1;
        din     = v.din;
        e.err   = RB ? v.exp_err : 1'b0;
        e.q     = v.exp_q;
        e.chk_q = (v.fmode == 0);
        sb.push_back(e);
        for (int k = 1; k <= P + S + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0;
                chk("err_cleared", err, 0);
            end
            chk("never_both_low", s_n | r_n, 1);
            if (k <= P) begin
                chk("pulse", {s_n, r_n}, v.din ? 2'b01 : 2'b10);
                chk("busy", ready, 0);
            end else if (k <= P + S) begin
                chk("settle", {s_n, r_n, ready, done}, 4'b1100);
            end else if (k == P + S + 1) begin
                chk("done", done, 1);
                if (done === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("err", err, e.err);
                    if (e.chk_q) chk("q_fb", q_fb, e.q);
                end
            end else begin
                chk("ready_back", {ready, done, err}, {1'b1, 1'b0, e.err});
            end
        end
        fmode = 0;
    endtask

    initial begin
        int n_done;
        vecs[0] = '{din: 1'b1, fmode: 0, exp_q: 1'b1, exp_err: 1'b0};
        vecs[1] = '{din: 1'b0, fmode: 0, exp_q: 1'b0, exp_err: 1'b0};
        vecs[2] = '{din: 1'b0, fmode: 0, exp_q: 1'b0, exp_err: 1'b0};
        vecs[3] = '{din: 1'b1, fmode: 1, exp_q: 1'b1, exp_err: 1'b1};
        vecs[4] = '{din: 1'b1, fmode: 0, exp_q: 1'b1, exp_err: 1'b0};
        vecs[5] = '{din: 1'b0, fmode: 2, exp_q: 1'b0, exp_err: 1'b1};
        vecs[6] = '{din: 1'b0, fmode: 0, exp_q: 1'b0, exp_err: 1'b0};

        repeat (2) @(negedge clk);
        chk("in_reset", {s_n, r_n, ready, done, err}, 5'b11100);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {s_n, r_n, ready, done, err}, 5'b11100);
        end

        foreach (vecs[i]) do_write(vecs[i]);

        // Request during a busy write is dropped, never queued.
        wait_ready();
        req = 1'b1; din = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (k == 2) begin req = 1'b1; din = 1'b0; end
            if (k == 3) req = 1'b0;
            if (done === 1'b1) n_done++;
            chk("busy_r_n", r_n, 1);
        end
        chk("busy_one_done", n_done, 1);
        chk("busy_latch", q_fb, 1);

        // Request held high gives back-to-back full writes.
        wait_ready();
        req = 1'b1; din = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) req = 1'b0;
            if (done === 1'b1) n_done++;
            if (k == 7 || k == 15) chk("b2b_done_cycle", done, 1);
            if (k == 9) chk("b2b_busy", ready, 0);
        end
        chk("b2b_dones", n_done, 2);
        chk("b2b_latch", q_fb, 0);

        // Reset mid-pulse releases s_n asynchronously.
        wait_ready();
        req = 1'b1; din = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("mid_pulse", s_n, 0);
        #1 rst = 1'b1;
        #1 chk("async_release", {s_n, r_n, ready, done}, 4'b1110);
        @(negedge clk);
        chk("held_reset", {s_n, r_n, ready, done}, 4'b1110);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("rst_no_done", n_done, 0);
        chk("rst_ready", ready, 1);
        sb.delete();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
